dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_if.sv | 31 +++
 rtl/dmem_ctrl.sv | 159 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Data-memory bus between the MEM-stage controller and the memory.
// Request fields hold steady while mem_req is high; mem_ack is a single-cycle strobe.
interface dmem_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// MEM-stage data memory controller: issues load/store requests, stalls the
// pipeline until ack or timeout, and flags misaligned/unsupported accesses.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  EXMEM_opcode_out,
  input  logic [2:0]  EXMEM_funct3_out,
  input  logic [31:0] EXMEM_data_addr_out,
  input  logic [31:0] EXMEM_store_data,
  dmem_ctrl_if.master mem,
  output logic        stall,
  output logic [31:0] MEMWB_data_read,
  output logic        access_err
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [8:0] TO       = 9'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [8:0]  cnt_inc;
  logic        is_load;
  logic        is_store;
  logic        access;
  logic        fn_ok;
  logic        aligned;
  logic        legal;
  logic        timeout_hit;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [1:0]  lane;

  assign is_load     = EXMEM_opcode_out == OP_LOAD;
  assign is_store    = EXMEM_opcode_out == OP_STORE;
  assign access      = is_load | is_store;
  assign lane        = EXMEM_data_addr_out[1:0];
  assign cnt_inc     = {1'b0, cnt} + 9'd1;
  assign timeout_hit = cnt_inc >= TO;
  assign legal       = access & fn_ok & aligned;

  always_comb begin
    fn_ok   = 1'b0;
    aligned = 1'b0;
    unique case (EXMEM_funct3_out)
      3'd0: begin
        fn_ok   = 1'b1;
        aligned = 1'b1;
      end
      3'd1: begin
        fn_ok   = 1'b1;
        aligned = ~lane[0];
      end
      3'd2: begin
        fn_ok   = 1'b1;
        aligned = lane == 2'b00;
      end
      3'd4: begin
        fn_ok   = is_load;
        aligned = 1'b1;
      end
      3'd5: begin
        fn_ok   = is_load;
        aligned = ~lane[0];
      end
      default: begin
        fn_ok   = 1'b0;
        aligned = 1'b0;
      end
    endcase
  end

  // Loads fetch the whole word; stores replicate data across the lanes
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = '0;
    if (is_store) begin
      unique case (EXMEM_funct3_out[1:0])
        2'd0: begin
          be_nxt    = 4'b0001 << lane;
          wdata_nxt = {4{EXMEM_store_data[7:0]}};
        end
        2'd1: begin
          be_nxt    = 4'b0011 << lane;
          wdata_nxt = {2{EXMEM_store_data[15:0]}};
        end
        default: begin
          be_nxt    = 4'b1111;
          wdata_nxt = EXMEM_store_data;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (access) state_nxt = legal ? WAIT : DONE;
      WAIT: if (mem.mem_ack || timeout_hit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stall = (state == IDLE && legal) || state == WAIT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt             <= '0;
      mem.mem_req     <= 1'b0;
      mem.mem_we      <= 1'b0;
      mem.mem_addr    <= '0;
      mem.mem_wdata   <= '0;
      mem.mem_be      <= '0;
      MEMWB_data_read <= '0;
      access_err      <= 1'b0;
    end else begin
      access_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (legal) begin
            cnt           <= '0;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= is_store;
            mem.mem_addr  <= {EXMEM_data_addr_out[31:2], 2'b00};
            mem.mem_wdata <= wdata_nxt;
            mem.mem_be    <= be_nxt;
          end else if (access) begin
            access_err <= 1'b1;
          end
        end
        WAIT: begin
          // ack takes priority over a timeout landing on the same cycle
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            if (!mem.mem_we) MEMWB_data_read <= mem.mem_rdata;
          end else if (timeout_hit) begin
            mem.mem_req     <= 1'b0;
            access_err      <= 1'b1;
            MEMWB_data_read <= '0;
          end else begin
            cnt <= cnt_inc[7:0];
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, reset-in-WAIT
// sequence, and randomized accesses against a transaction-level model.
module tb_dmem_ctrl;
  localparam int TO = 15;
  localparam logic [6:0] LD  = 7'h03;
  localparam logic [6:0] ST  = 7'h23;
  localparam logic [6:0] NOP = 7'h13;
  localparam logic [6:0] ALU = 7'h33;

  typedef struct {
    int          req_n;
    int          stall_n;
    int          err_n;
    logic        we;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [31:0] rd;
    bit          unstable;
    bit          hung;
  } res_t;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    int          ack_at;
    logic [31:0] rdata;
    bit          chain;
    res_t        exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] daddr;
  logic [31:0] sdata;
  logic        stall;
  logic [31:0] MEMWB_data_read;
  logic        access_err;
  logic [31:0] rd_model;
  int          checks;
  int          errors;

  dmem_ctrl_if m();

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk                 (clk),
    .reset               (reset),
    .EXMEM_opcode_out    (opcode),
    .EXMEM_funct3_out    (funct3),
    .EXMEM_data_addr_out (daddr),
    .EXMEM_store_data    (sdata),
    .mem                 (m),
    .stall               (stall),
    .MEMWB_data_read     (MEMWB_data_read),
    .access_err          (access_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s act=%h exp=%h", tag, nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    logic [6:0] op, logic [2:0] f3, logic [31:0] addr, logic [31:0] data,
    int ack_at, logic [31:0] rdata, bit chain,
    int req_n, int stall_n, int err_n, logic we, logic [3:0] be,
    logic [31:0] maddr, logic [31:0] wdata, logic [31:0] rd);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.data = data;
    v.ack_at = ack_at; v.rdata = rdata; v.chain = chain;
    v.exp = '{req_n, stall_n, err_n, we, be, maddr, wdata, rd, 1'b0, 1'b0};
    return v;
  endfunction

  // Transaction-level expectation from the access rules
  function automatic res_t model(logic [6:0] op, logic [2:0] f3,
                                 logic [31:0] addr, logic [31:0] data,
                                 int ack_at, logic [31:0] rdata);
    res_t r;
    bit ld, st, ok;
    int sz, n;
    r = '{0, 0, 0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    ld = op == LD;
    st = op == ST;
    if (!ld && !st) begin
      r.rd = rd_model;
      return r;
    end
    ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz = 1 << (int'(f3) % 4);
    if (int'(addr % 4) % sz != 0) ok = 1'b0;
    if (!ok) begin
      r.err_n = 1;
      r.rd = rd_model;
      return r;
    end
    n = (ack_at >= 1 && ack_at <= TO) ? ack_at : TO;
    r.req_n = n;
    r.stall_n = n + 1;
    r.err_n = (ack_at < 1 || ack_at > TO) ? 1 : 0;
    r.we = st;
    r.maddr = addr - (addr % 4);
    r.be = ld ? 4'hF : 4'(((1 << sz) - 1) << int'(addr % 4));
    if (sz == 1)      r.wdata = data[7:0] * 32'h01010101;
    else if (sz == 2) r.wdata = data[15:0] * 32'h00010001;
    else              r.wdata = data;
    if (ld) rd_model = r.err_n != 0 ? 32'h0 : rdata;
    r.rd = rd_model;
    return r;
  endfunction

  // Presents one instruction and lets it leave MEM once stall drops
  task automatic run_access(input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] data,
                            input int ack_at, input logic [31:0] rdata,
                            input bit chain, input bit stray, output res_t r);
    bit adv, fin;
    int post;
    r = '{0, 0, 0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    adv = 0; fin = 0; post = 0;
    opcode = op; funct3 = f3; daddr = addr; sdata = data;
    m.mem_ack = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      r.err_n += int'(access_err);
      if (!adv) begin
        if (stall) r.stall_n++;
        if (m.mem_req) begin
          r.req_n++;
          if (r.req_n == 1) begin
            r.we = m.mem_we; r.be = m.mem_be;
            r.maddr = m.mem_addr; r.wdata = m.mem_wdata;
          end else if (r.we !== m.mem_we || r.be !== m.mem_be ||
                       r.maddr !== m.mem_addr || r.wdata !== m.mem_wdata) begin
            r.unstable = 1'b1;
          end
        end
        if (!stall) adv = 1;
      end else begin
        post++;
      end
      if (m.mem_req && r.req_n == ack_at) begin
        m.mem_ack = 1'b1;
        m.mem_rdata = rdata;
      end else if (!m.mem_req && stray) begin
        m.mem_ack = 1'($urandom % 2);
        m.mem_rdata = $urandom;
      end else begin
        m.mem_rdata = $urandom;
      end
      @(posedge clk);
      #1;
      m.mem_ack = 1'b0;
      if (adv && post == 0) begin
        if (chain) fin = 1;
        else opcode = NOP;
      end
      if (post == 2) fin = 1;
    end
    r.hung = !fin;
    r.rd = MEMWB_data_read;
  endtask

  task automatic compare(input string tag, input res_t a, input res_t e);
    chk(tag, "hung", 32'(a.hung), 32'h0);
    chk(tag, "req_cycles", a.req_n, e.req_n);
    chk(tag, "stall_cycles", a.stall_n, e.stall_n);
    chk(tag, "err_pulses", a.err_n, e.err_n);
    chk(tag, "data_read", a.rd, e.rd);
    if (e.req_n > 0) begin
      chk(tag, "we", 32'(a.we), 32'(e.we));
      chk(tag, "be", 32'(a.be), 32'(e.be));
      chk(tag, "addr", a.maddr, e.maddr);
      chk(tag, "stable", 32'(a.unstable), 32'h0);
      if (e.we) chk(tag, "wdata", a.wdata, e.wdata);
    end
  endtask

  vec_t vecs[17];
  res_t r, e;

  initial begin
    bit got;
    checks = 0; errors = 0; rd_model = '0;

    vecs[0]  = mkv(LD, 3'd2, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0,
                   3, 4, 0, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF);
    vecs[1]  = mkv(ST, 3'd0, 32'h203, 32'hA5, 1, 32'h0, 0,
                   1, 2, 0, 1'b1, 4'h8, 32'h200, 32'hA5A5A5A5, 32'hDEADBEEF);
    vecs[2]  = mkv(LD, 3'd1, 32'h101, 32'h0, 1, 32'h0, 0,
                   0, 0, 1, 1'b0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF);
    vecs[3]  = mkv(ST, 3'd3, 32'h400, 32'h0, 1, 32'h0, 0,
                   0, 0, 1, 1'b0, 4'h0, 32'h0, 32'h0, 32'hDEADBEEF);
    vecs[4]  = mkv(LD, 3'd2, 32'h104, 32'h0, 0, 32'h0, 0,
                   15, 16, 1, 1'b0, 4'hF, 32'h104, 32'h0, 32'h0);
    vecs[5]  = mkv(ST, 3'd1, 32'h302, 32'h1234, 2, 32'h0, 0,
                   2, 3, 0, 1'b1, 4'hC, 32'h300, 32'h12341234, 32'h0);
    vecs[6]  = mkv(LD, 3'd4, 32'h107, 32'h0, 1, 32'h11223344, 0,
                   1, 2, 0, 1'b0, 4'hF, 32'h104, 32'h0, 32'h11223344);
    vecs[7]  = mkv(ST, 3'd2, 32'h10, 32'hCAFEF00D, 15, 32'h0, 0,
                   15, 16, 0, 1'b1, 4'hF, 32'h10, 32'hCAFEF00D, 32'h11223344);
    vecs[8]  = mkv(LD, 3'd2, 32'h102, 32'h0, 1, 32'h0, 0,
                   0, 0, 1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h11223344);
    vecs[9]  = mkv(LD, 3'd5, 32'h106, 32'h0, 4, 32'h0BAD0BAD, 0,
                   4, 5, 0, 1'b0, 4'hF, 32'h104, 32'h0, 32'h0BAD0BAD);
    vecs[10] = mkv(ST, 3'd4, 32'h20, 32'h0, 1, 32'h0, 0,
                   0, 0, 1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0BAD0BAD);
    vecs[11] = mkv(ALU, 3'd2, 32'h40, 32'h0, 1, 32'h0, 0,
                   0, 0, 0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0BAD0BAD);
    vecs[12] = mkv(LD, 3'd0, 32'h3, 32'h0, 1, 32'h55, 0,
                   1, 2, 0, 1'b0, 4'hF, 32'h0, 32'h0, 32'h55);
    vecs[13] = mkv(ST, 3'd1, 32'h301, 32'h0, 1, 32'h0, 0,
                   0, 0, 1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h55);
    vecs[14] = mkv(LD, 3'd1, 32'h102, 32'h0, 2, 32'h7777, 0,
                   2, 3, 0, 1'b0, 4'hF, 32'h100, 32'h0, 32'h7777);
    vecs[15] = mkv(LD, 3'd2, 32'h500, 32'h0, 15, 32'h600DF00D, 1,
                   15, 16, 0, 1'b0, 4'hF, 32'h500, 32'h0, 32'h600DF00D);
    vecs[16] = mkv(ST, 3'd2, 32'h504, 32'h13579BDF, 15, 32'h0, 0,
                   15, 16, 0, 1'b1, 4'hF, 32'h504, 32'h13579BDF, 32'h600DF00D);

    reset = 1'b1; opcode = NOP; funct3 = '0; daddr = '0; sdata = '0;
    m.mem_ack = 1'b0; m.mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("reset", "mem_req", 32'(m.mem_req), 32'h0);
    chk("reset", "mem_we", 32'(m.mem_we), 32'h0);
    chk("reset", "mem_addr", m.mem_addr, 32'h0);
    chk("reset", "mem_wdata", m.mem_wdata, 32'h0);
    chk("reset", "mem_be", 32'(m.mem_be), 32'h0);
    chk("reset", "data_read", MEMWB_data_read, 32'h0);
    chk("reset", "access_err", 32'(access_err), 32'h0);
    chk("reset", "stall", 32'(stall), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_access(vecs[i].op, vecs[i].f3, vecs[i].addr, vecs[i].data,
                 vecs[i].ack_at, vecs[i].rdata, vecs[i].chain, 1'b0, r);
      e = model(vecs[i].op, vecs[i].f3, vecs[i].addr, vecs[i].data,
                vecs[i].ack_at, vecs[i].rdata);
      compare($sformatf("vec%0d", i), r, vecs[i].exp);
    end

    // Reset in the middle of a pending load
    opcode = LD; funct3 = 3'd2; daddr = 32'h700; sdata = '0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (m.mem_req) got = 1;
    end
    chk("rst_wait", "req_seen", 32'(got), 32'h1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_wait", "mem_req", 32'(m.mem_req), 32'h0);
    chk("rst_wait", "access_err", 32'(access_err), 32'h0);
    chk("rst_wait", "data_read", MEMWB_data_read, 32'h0);
    rd_model = '0;
    opcode = NOP;
    m.mem_ack = 1'b1; m.mem_rdata = 32'hBADBAD00;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    m.mem_ack = 1'b0;
    @(negedge clk);
    chk("rst_ack", "mem_req", 32'(m.mem_req), 32'h0);
    chk("rst_ack", "stall", 32'(stall), 32'h0);
    chk("rst_ack", "access_err", 32'(access_err), 32'h0);
    chk("rst_ack", "data_read", MEMWB_data_read, 32'h0);
    @(posedge clk);
    #1;
    run_access(ST, 3'd1, 32'h302, 32'h1234, 1, 32'h0, 0, 1'b0, r);
    e = model(ST, 3'd1, 32'h302, 32'h1234, 1, 32'h0);
    compare("rst_sh", r, e);
    chk("rst_sh", "be_const", 32'(r.be), 32'hC);
    chk("rst_sh", "wdata_const", r.wdata, 32'h12341234);

    for (int i = 0; i < 60; i++) begin
      logic [6:0] op;
      logic [2:0] f3;
      logic [31:0] addr, data, rdata;
      int sel, ack_at;
      bit chain;
      sel = $urandom % 8;
      op = sel < 3 ? LD : sel < 6 ? ST : sel == 6 ? NOP : ALU;
      f3 = 3'($urandom);
      addr = $urandom;
      data = $urandom;
      rdata = $urandom;
      ack_at = $urandom_range(0, TO + 2);
      e = model(op, f3, addr, data, ack_at, rdata);
      chain = (e.req_n > 0) && i < 59 && ($urandom % 2 == 1);
      run_access(op, f3, addr, data, ack_at, rdata, chain, 1'($urandom % 2), r);
      compare($sformatf("rnd%0d", i), r, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
